// File: rtl/gpr_file_sb.sv
// gpr_file_sb: MIPS32 general-purpose register file.
// One synchronous writeback port, NUM_RD combinational read ports with
// write-to-read bypass, and a per-register load-pending scoreboard with a
// registered count of pending registers.
//
// Interface timing: there is no valid/ready handshake anywhere in this block.
// Every request (writeback, read, scoreboard set) is accepted in the cycle it
// is presented; the block never applies backpressure, and stall decisions
// are left to ID, which uses rd_pending.
module gpr_file_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_pending,
   input  logic                     sb_set_en,
   input  logic [ADDR_W-1:0]        sb_set_addr,
   output logic [ADDR_W:0]          pending_cnt
);

   localparam int NREG = 2**ADDR_W;

   // Architectural state.
   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   pend;
   logic [ADDR_W:0]   cnt_q;

   // Effective (register-0 filtered) update requests.
   logic set_eff;
   logic clr_eff;
   logic cnt_inc;
   logic cnt_dec;

   // Per-port unpacked read addresses.
   logic [ADDR_W-1:0] rd_a [NUM_RD];

   assign set_eff = sb_set_en && (sb_set_addr != '0);
   assign clr_eff = wr_en && (wr_addr != '0);

   // Net change of the pending population this cycle. A set only adds when
   // the bit was clear; a clear only removes when the bit was set and is not
   // simultaneously re-set (set wins on a same-address collision).
   always_comb begin
      cnt_inc = set_eff && !pend[sb_set_addr];
      cnt_dec = clr_eff && pend[wr_addr] && !(set_eff && (sb_set_addr == wr_addr));
   end

   // Register array: writeback lands one edge after it is presented; r0 is never written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NREG; k++) begin
            regs[k] <= '0;
         end
      end else if (clr_eff) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Scoreboard bits: writeback clears first, a load issue then sets (set wins).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
      end else begin
         for (int k = 1; k < NREG; k++) begin
            if (set_eff && (sb_set_addr == k[ADDR_W-1:0])) begin
               pend[k] <= 1'b1;
            end else if (clr_eff && (wr_addr == k[ADDR_W-1:0])) begin
               pend[k] <= 1'b0;
            end
         end
         pend[0] <= 1'b0;
      end
   end

   // Pending count tracks the scoreboard population by its net change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
      end
   end

   assign pending_cnt = cnt_q;

   // Slice the packed read-address bus into per-port addresses.
   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_addr
      assign rd_a[i] = rd_addr[i*ADDR_W +: ADDR_W];
   end

   // Read ports: disabled/r0 -> 0, same-cycle writeback bypass, else array.
   // Outputs are forced to 0 while reset is held so an in-flight write
   // cannot leak through the bypass path.
   always_comb begin
      rd_data    = '0;
      rd_pending = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (rst_n && rd_en[i] && (rd_a[i] != '0)) begin
            if (wr_en && (wr_addr == rd_a[i])) begin
               rd_data[i*DATA_W +: DATA_W] = wr_data;
               rd_pending[i]               = 1'b0;
            end else begin
               rd_data[i*DATA_W +: DATA_W] = regs[rd_a[i]];
               rd_pending[i]               = pend[rd_a[i]];
            end
         end
      end
   end

endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
Parametrised general-purpose register file for the MIPS32 pipeline. It has one synchronous write port from MEM-WB and NUM_RD combinational read ports to ID. The write port bypasses to same-cycle reads, so writeback-to-decode RAW hazards resolve without a stall. A per-register pending scoreboard tracks outstanding loads, and ID uses it to generate load-use stalls.

Parameters:
DATA_W  32  register width in bits
ADDR_W  5  register address width; register count is 2**ADDR_W
NUM_RD  2  number of independent read ports (1..4)

Ports:
clk  input  1  clock; all state updates on its rising edge
rst_n  input  1  asynchronous, active-low reset
wr_en  input  1  writeback enable from MEM-WB
wr_addr  input  ADDR_W  writeback destination register
wr_data  input  DATA_W  writeback data
rd_en  input  NUM_RD  per-port read enable from ID
rd_addr  input  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W]
rd_pending  output  NUM_RD  per-port flag: the read register awaits an outstanding load
sb_set_en  input  1  ID issues a load; mark its destination pending
sb_set_addr  input  ADDR_W  load destination register
pending_cnt  output  ADDR_W+1  registered count of pending registers

Behaviour:
- Reset (rst_n low, asynchronous): all registers cleared to 0, all pending bits cleared, pending_cnt = 0.
  - While rst_n is low: rd_data = 0 and rd_pending = 0 on all ports.
  - Writes and scoreboard sets are ignored.
  - Reset asserted mid-operation discards any in-flight write immediately.
- Register 0:
  - Never written, never marked pending.
  - Reads of address 0 always return 0 with rd_pending = 0.
- Write:
  - On a rising edge with wr_en = 1 and wr_addr != 0, the register at wr_addr takes wr_data.
  - Write latency is 1 cycle into the array.
- Read, per port i (combinational, 0-cycle latency), in priority order:
  1. rd_en[i] = 0 or addr = 0 -> rd_data = 0.
  2. wr_en = 1 and wr_addr = addr -> rd_data = wr_data (bypass).
  3. Otherwise -> rd_data = the array content.
  - All ports are independent. Several ports may read the same address, including the bypassed one, and each sees the same value.
- Scoreboard, one pending bit per register, updated on each rising edge:
  - Set: sb_set_en = 1 and sb_set_addr != 0 -> bit[sb_set_addr] <= 1.
  - Clear: wr_en = 1 and wr_addr != 0 -> bit[wr_addr] <= 0.
  - Set and clear on the same address in the same cycle: set wins, and the bit stays/becomes 1. This case means a new load is issued to a register being written back.
  - Setting an already-pending bit leaves it at 1 and pending_cnt unchanged.
  - Clearing a bit that is not pending: no change.
- rd_pending[i] (combinational) = rd_en[i] and addr != 0 and bit[addr] and not (wr_en and wr_addr = addr).
  - A same-cycle writeback therefore lifts the stall, because the data arrives through the bypass.
- pending_cnt (registered):
  - Each edge it becomes the count of set bits after the update.
  - It is incremented or decremented by the net change, so it moves by -1, 0 or +1 per cycle.
  - Range is 0 to 2**ADDR_W - 1; the count never wraps.
- There is no backpressure. The block never stalls its producers; stall decisions belong to ID.

Test Plan:
- Reset then read: release rst_n, then read r5 on ports 0 and 1 -> rd_data = 0, rd_pending = 0, pending_cnt = 0.
- Write then read: write r3 = 0xDEADBEEF, then read r3 next cycle -> 0xDEADBEEF. Write r0 = 0x12345678, then read r0 -> 0.
- Bypass: wr_en = 1, wr_addr = 7, wr_data = 0xA5A5A5A5, with port 0 and port 1 both reading r7 in the same cycle, array r7 = 0x1 -> both ports return 0xA5A5A5A5.
- Scoreboard set/clear: set r9 -> next cycle, reading r9 gives rd_pending = 1 and pending_cnt = 1. Write r9 in a later cycle -> rd_pending = 0 in that cycle and pending_cnt = 0 after the edge.
- Set/clear collision: with r4 pending, assert sb_set r4 and write r4 in the same cycle -> bit stays 1, pending_cnt stays 1, and r4 holds the written data.
- Reset mid-operation: with r2 and r6 pending and a write to r2 active, pulse rst_n low between edges -> everything cleared immediately: rd_data = 0, pending_cnt = 0, r2 = 0 after release.
